// File: rtl/branch_resolve_log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_log_pkg
// Description : Shared encodings and field positions for the branch resolve
//               log and the 2-bit dynamic predictor it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_log_pkg;

    // 2-bit saturating predictor counter encodings
    typedef enum logic [1:0] {
        SN = 2'b00,   // strongly not-taken
        WN = 2'b01,   // weakly not-taken
        WT = 2'b10,   // weakly taken
        ST = 2'b11    // strongly taken
    } pred_cnt_e;

    // Per-entry status flags; alt_pc is held in a separate array
    localparam int ENT_FLAGS_W  = 4;
    localparam int ENT_VALID    = 3;
    localparam int ENT_RESOLVED = 2;
    localparam int ENT_PRED     = 1;
    localparam int ENT_MISPRED  = 0;

    // Default PC width
    localparam int DEFAULT_PC_W = 16;

endpackage
`default_nettype wire

// File: rtl/brl_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : brl_ptr_ctrl
// Description : Head/tail pointers (with wrap bit) for the branch resolve log,
//               full/empty detection and flush-tail computation.
// Revision    : 1.0 - initial release
// ============================================================================
module brl_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tail_inc,
    input  logic             head_inc,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    output logic [TAG_W-1:0] head_idx,
    output logic [TAG_W-1:0] tail_idx,
    output logic             empty,
    output logic             full
);

    logic [TAG_W:0]   r_head;
    logic [TAG_W:0]   r_tail;
    logic [TAG_W-1:0] w_dist;
    logic [TAG_W:0]   w_flush_tail;

    // Distance of the mispredicted tag from head wraps naturally mod DEPTH;
    // the new tail sits just past it, wrap bit carried by the wider add.
    assign w_dist       = flush_tag - r_head[TAG_W-1:0];
    assign w_flush_tail = r_head + {1'b0, w_dist} + {{TAG_W{1'b0}}, 1'b1};

    assign head_idx = r_head[TAG_W-1:0];
    assign tail_idx = r_tail[TAG_W-1:0];
    assign empty    = (r_head == r_tail);
    assign full     = (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]) &&
                      (r_head[TAG_W] != r_tail[TAG_W]);

    // Pointer update: commit advances head; flush rewinds tail, else allocate advances it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (head_inc) begin
                r_head <= r_head + {{TAG_W{1'b0}}, 1'b1};
            end
            if (flush) begin
                r_tail <= w_flush_tail;
            end else if (tail_inc) begin
                r_tail <= r_tail + {{TAG_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_log.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_log
// Description : In-order log of predicted branches. Checks execute outcomes
//               against the logged prediction, issues mispredict/redirect with
//               younger-branch flush, and emits predictor update pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_log
    import branch_resolve_log_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    parameter int PC_W  = DEFAULT_PC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic             alloc_taken,
    input  logic [PC_W-1:0]  alloc_alt_pc,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             log_full,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic             commit_valid,
    output logic             commit_rdy,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             mispred_num,
    output logic             decr_count_brnch,
    output logic             brnc_pred_log
);

    logic [ENT_FLAGS_W-1:0] r_flags  [DEPTH];
    logic [PC_W-1:0]        r_alt_pc [DEPTH];

    logic [TAG_W-1:0] w_head_idx;
    logic [TAG_W-1:0] w_tail_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_res_ok;
    logic             w_flush;
    logic             w_alloc_fire;
    logic             w_commit_rdy;
    logic             w_commit_fire;
    logic             w_head_mispred;
    logic [TAG_W-1:0] w_res_dist;
    logic [DEPTH-1:0] w_kill;

    brl_ptr_ctrl #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .tail_inc  (w_alloc_fire),
        .head_inc  (w_commit_fire),
        .flush     (w_flush),
        .flush_tag (resolve_tag),
        .head_idx  (w_head_idx),
        .tail_idx  (w_tail_idx),
        .empty     (w_empty),
        .full      (w_full)
    );

    // Only a live, still-unresolved entry can be resolved; a wrong direction flushes
    assign w_res_ok       = resolve_valid && r_flags[resolve_tag][ENT_VALID] &&
                            !r_flags[resolve_tag][ENT_RESOLVED];
    assign w_flush        = w_res_ok && (resolve_taken != r_flags[resolve_tag][ENT_PRED]);
    assign w_alloc_fire   = alloc_valid && !w_full && !w_flush;
    assign w_commit_rdy   = !w_empty && r_flags[w_head_idx][ENT_RESOLVED] && !w_flush;
    assign w_commit_fire  = commit_valid && w_commit_rdy;
    assign w_head_mispred = r_flags[w_head_idx][ENT_MISPRED];
    assign w_res_dist     = resolve_tag - w_head_idx;

    assign alloc_tag  = w_tail_idx;
    assign log_full   = w_full;
    assign commit_rdy = w_commit_rdy;

    // Slots younger than the mispredicted tag (further from head) are wrong-path
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
        assign w_kill[gi] = w_flush && ((TAG_W'(gi) - w_head_idx) > w_res_dist);
    end

    // Entry status flags: allocate, resolve, commit and flush invalidation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_commit_fire && (w_head_idx == TAG_W'(i))) begin
                    r_flags[i] <= '0;
                end
                if (w_alloc_fire && (w_tail_idx == TAG_W'(i))) begin
                    r_flags[i][ENT_VALID]    <= 1'b1;
                    r_flags[i][ENT_RESOLVED] <= 1'b0;
                    r_flags[i][ENT_PRED]     <= alloc_taken;
                    r_flags[i][ENT_MISPRED]  <= 1'b0;
                end
                if (w_res_ok && (resolve_tag == TAG_W'(i))) begin
                    r_flags[i][ENT_RESOLVED] <= 1'b1;
                    if (w_flush) begin
                        r_flags[i][ENT_MISPRED] <= 1'b1;
                    end
                end
                if (w_kill[i]) begin
                    r_flags[i] <= '0;
                end
            end
        end
    end

    // Redirect target storage; contents are only meaningful while the flag is valid
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_alt_pc[w_tail_idx] <= alloc_alt_pc;
        end
    end

    // Predictor-facing outputs, registered one cycle after the causing event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            mispred_num      <= 1'b0;
            decr_count_brnch <= 1'b0;
            brnc_pred_log    <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            mispredict       <= w_flush;
            mispred_num      <= w_flush && (resolve_tag == w_head_idx);
            decr_count_brnch <= w_commit_fire && !w_head_mispred;
            if (w_flush) begin
                redirect_pc   <= r_alt_pc[resolve_tag];
                brnc_pred_log <= r_flags[resolve_tag][ENT_PRED];
            end else if (w_commit_fire && !w_head_mispred) begin
                brnc_pred_log <= r_flags[w_head_idx][ENT_PRED];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_log.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_log
// Description : Directed self-checking bench for branch_resolve_log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_log;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int PC_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             alloc_valid;
    logic             alloc_taken;
    logic [PC_W-1:0]  alloc_alt_pc;
    logic [TAG_W-1:0] alloc_tag;
    logic             log_full;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_taken;
    logic             commit_valid;
    logic             commit_rdy;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             mispred_num;
    logic             decr_count_brnch;
    logic             brnc_pred_log;

    int n_cmp;
    int n_err;

    branch_resolve_log #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PC_W  (PC_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_valid      (alloc_valid),
        .alloc_taken      (alloc_taken),
        .alloc_alt_pc     (alloc_alt_pc),
        .alloc_tag        (alloc_tag),
        .log_full         (log_full),
        .resolve_valid    (resolve_valid),
        .resolve_tag      (resolve_tag),
        .resolve_taken    (resolve_taken),
        .commit_valid     (commit_valid),
        .commit_rdy       (commit_rdy),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .mispred_num      (mispred_num),
        .decr_count_brnch (decr_count_brnch),
        .brnc_pred_log    (brnc_pred_log)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, land 1ns after the edge and return inputs to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        commit_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_valid = 1'b0; resolve_valid = 1'b0; commit_valid = 1'b0;
        alloc_taken = 1'b0; alloc_alt_pc = '0; resolve_tag = '0; resolve_taken = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic taken, input logic [PC_W-1:0] alt);
        alloc_valid  = 1'b1;
        alloc_taken  = taken;
        alloc_alt_pc = alt;
        cyc();
    endtask

    task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken);
        resolve_valid = 1'b1;
        resolve_tag   = tag;
        resolve_taken = taken;
        cyc();
    endtask

    task automatic commit();
        commit_valid = 1'b1;
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_mispred_num", 32'(mispred_num), 0);
        chk("rst_decr", 32'(decr_count_brnch), 0);
        chk("rst_pred_log", 32'(brnc_pred_log), 0);
        chk("rst_redirect", 32'(redirect_pc), 0);
        chk("rst_full", 32'(log_full), 0);
        chk("rst_commit_rdy", 32'(commit_rdy), 0);
        chk("rst_alloc_tag", 32'(alloc_tag), 0);

        // ---------------- basic correct prediction ----------------
        alloc(1'b1, 16'h0040);
        chk("s1_tag_next", 32'(alloc_tag), 1);
        chk("s1_rdy_unresolved", 32'(commit_rdy), 0);
        resolve(2'd0, 1'b1);
        chk("s1_no_mispredict", 32'(mispredict), 0);
        chk("s1_rdy_resolved", 32'(commit_rdy), 1);
        commit();
        chk("s1_decr", 32'(decr_count_brnch), 1);
        chk("s1_pred_log", 32'(brnc_pred_log), 1);
        chk("s1_mispredict_quiet", 32'(mispredict), 0);
        cyc();
        chk("s1_decr_pulse", 32'(decr_count_brnch), 0);
        chk("s1_pred_log_hold", 32'(brnc_pred_log), 1);
        chk("s1_empty_rdy", 32'(commit_rdy), 0);

        // ---------------- mispredict with younger flush ----------------
        do_reset();
        alloc(1'b1, 16'h0100);
        alloc(1'b0, 16'h0200);
        alloc(1'b1, 16'h0300);
        chk("s2_tag3", 32'(alloc_tag), 3);
        resolve(2'd0, 1'b1);
        resolve(2'd1, 1'b1);
        chk("s2_mispredict", 32'(mispredict), 1);
        chk("s2_redirect", 32'(redirect_pc), 32'h0200);
        chk("s2_mispred_num", 32'(mispred_num), 0);
        chk("s2_pred_log", 32'(brnc_pred_log), 0);
        chk("s2_tail_after_flush", 32'(alloc_tag), 2);
        resolve(2'd2, 1'b1);
        chk("s2_flushed_ignored", 32'(mispredict), 0);
        chk("s2_redirect_hold", 32'(redirect_pc), 32'h0200);
        chk("s2_rdy_tag0", 32'(commit_rdy), 1);
        commit();
        chk("s2_decr_tag0", 32'(decr_count_brnch), 1);
        chk("s2_predlog_tag0", 32'(brnc_pred_log), 1);
        chk("s2_rdy_tag1", 32'(commit_rdy), 1);
        commit();
        chk("s2_silent_tag1", 32'(decr_count_brnch), 0);
        chk("s2_silent_mp", 32'(mispredict), 0);
        chk("s2_empty", 32'(commit_rdy), 0);

        // ---------------- full log, drop, wrap ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("s3_fill_not_full", 32'(log_full), 0);
            alloc(1'b1, 16'(16'h0010 * (i + 1)));
        end
        chk("s3_full", 32'(log_full), 1);
        alloc(1'b0, 16'h0BAD);
        chk("s3_drop_full", 32'(log_full), 1);
        chk("s3_drop_tag", 32'(alloc_tag), 0);
        resolve(2'd0, 1'b1);
        commit_valid = 1'b1;
        alloc_valid  = 1'b1;
        alloc_taken  = 1'b0;
        alloc_alt_pc = 16'h0BAD;
        cyc();
        chk("s3_commit_decr", 32'(decr_count_brnch), 1);
        chk("s3_refused_full", 32'(log_full), 0);
        chk("s3_wrap_tag", 32'(alloc_tag), 0);
        alloc(1'b0, 16'h0055);
        chk("s3_refull", 32'(log_full), 1);

        // ---------------- commit blocked by flush ----------------
        do_reset();
        alloc(1'b1, 16'h0010);
        alloc(1'b1, 16'h0020);
        resolve(2'd0, 1'b1);
        commit_valid  = 1'b1;
        resolve_valid = 1'b1;
        resolve_tag   = 2'd1;
        resolve_taken = 1'b0;
        #1;
        chk("s4_rdy_blocked", 32'(commit_rdy), 0);
        cyc();
        chk("s4_mispredict", 32'(mispredict), 1);
        chk("s4_no_decr", 32'(decr_count_brnch), 0);
        chk("s4_redirect", 32'(redirect_pc), 32'h0020);
        chk("s4_rdy_retry", 32'(commit_rdy), 1);
        commit();
        chk("s4_decr_retry", 32'(decr_count_brnch), 1);
        chk("s4_mp_quiet", 32'(mispredict), 0);

        // ---------------- wrapped head, flush across the wrap ----------------
        do_reset();
        for (int i = 0; i < 3; i++) alloc(1'b1, 16'h0001);
        for (int i = 0; i < 3; i++) resolve(2'(i), 1'b1);
        for (int i = 0; i < 3; i++) commit();
        chk("s5_head3_tag", 32'(alloc_tag), 3);
        alloc(1'b1, 16'h0030);
        alloc(1'b1, 16'h00A0);
        alloc(1'b1, 16'h00B0);
        alloc(1'b1, 16'h00C0);
        chk("s5_full", 32'(log_full), 1);
        resolve(2'd0, 1'b0);
        chk("s5_mispredict", 32'(mispredict), 1);
        chk("s5_redirect", 32'(redirect_pc), 32'h00A0);
        chk("s5_mispred_num", 32'(mispred_num), 0);
        chk("s5_tail_idx", 32'(alloc_tag), 1);
        chk("s5_not_full", 32'(log_full), 0);
        resolve(2'd1, 1'b0);
        chk("s5_flushed_ignored", 32'(mispredict), 0);
        alloc(1'b1, 16'h00D0);
        chk("s5_one_free", 32'(log_full), 0);
        alloc(1'b1, 16'h00E0);
        chk("s5_wrap_full", 32'(log_full), 1);
        resolve(2'd3, 1'b0);
        chk("s5_head_mispredict", 32'(mispredict), 1);
        chk("s5_head_mispred_num", 32'(mispred_num), 1);
        chk("s5_head_redirect", 32'(redirect_pc), 32'h0030);
        chk("s5_head_tail", 32'(alloc_tag), 0);
        cyc();
        chk("s5_num_pulse", 32'(mispred_num), 0);

        // ---------------- reset mid-flush ----------------
        do_reset();
        alloc(1'b1, 16'h0070);
        alloc(1'b1, 16'h0080);
        resolve_valid = 1'b1;
        resolve_tag   = 2'd0;
        resolve_taken = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("s6_rst_rdy", 32'(commit_rdy), 0);
        chk("s6_rst_tag", 32'(alloc_tag), 0);
        chk("s6_rst_full", 32'(log_full), 0);
        cyc();
        chk("s6_rst_mp", 32'(mispredict), 0);
        chk("s6_rst_redirect", 32'(redirect_pc), 0);
        rst_n = 1'b1;
        cyc();
        chk("s6_after_mp", 32'(mispredict), 0);
        chk("s6_after_decr", 32'(decr_count_brnch), 0);
        chk("s6_after_rdy", 32'(commit_rdy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
